// File: rtl/dual_rail_pkg.sv
// -----------------------------------------------------------------------------
// dual_rail_pkg
// Shared types and constants for the dual-rail link receiver:
//   - wpair_t          : wire pair written {bit1, bit0}
//   - W_00..W_11       : named wire-pair values
//   - SYM_ZERO..SYM_FD : 3-bit decoded symbol codes
//   - state_e          : decode FSM state encoding
// -----------------------------------------------------------------------------
package dual_rail_pkg;

    typedef logic [1:0] wpair_t;

    localparam wpair_t W_00 = 2'b00;
    localparam wpair_t W_01 = 2'b01;
    localparam wpair_t W_10 = 2'b10;
    localparam wpair_t W_11 = 2'b11;

    localparam logic [2:0] SYM_ZERO = 3'd0;
    localparam logic [2:0] SYM_ONE  = 3'd1;
    localparam logic [2:0] SYM_X0   = 3'd2;
    localparam logic [2:0] SYM_FE   = 3'd3;
    localparam logic [2:0] SYM_FS   = 3'd4;
    localparam logic [2:0] SYM_FD   = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_A0   = 4'd1,
        S_A1   = 4'd2,
        S_B0   = 4'd3,
        S_B1   = 4'd4,
        S_C_X0 = 4'd5,
        S_C_FS = 4'd6,
        S_C_FE = 4'd7,
        S_C_FD = 4'd8,
        S_HOLD = 4'd9,
        S_ERR  = 4'd10
    } state_e;

endpackage

// File: rtl/dual_rail_receiver_if.sv
// -----------------------------------------------------------------------------
// dual_rail_receiver_if
// Link-side signals of the dual-rail receiver.
//   bit0, bit1 : dual-rail wire pair (asynchronous to clk)
//   ack        : four-phase acknowledge back to the sender
//   sym        : decoded 3-bit symbol code
//   sym_valid  : sym holds an unconsumed symbol
//   sym_ready  : consumer accepts sym
//   err        : one-cycle protocol-violation pulse
// Modports: slave = the receiver, master = sender/consumer environment.
// -----------------------------------------------------------------------------
interface dual_rail_receiver_if;
    import dual_rail_pkg::*;

    logic       bit0;
    logic       bit1;
    logic       ack;
    logic [2:0] sym;
    logic       sym_valid;
    logic       sym_ready;
    logic       err;

    modport slave (
        input  bit0, bit1, sym_ready,
        output ack, sym, sym_valid, err
    );

    modport master (
        output bit0, bit1, sym_ready,
        input  ack, sym, sym_valid, err
    );
endinterface

// File: rtl/dual_rail_filter.sv
// -----------------------------------------------------------------------------
// dual_rail_filter
// Brings the wire pair into the clk domain and removes short glitches.
// A new pair value is accepted only after it has been seen for STABLE_CYCLES
// consecutive samples. On the accepting edge w_upd is high and w_next carries
// the value, so the decoder commits on the same edge as w_f.
// Macro DUAL_RAIL_SYNC_EN: when defined, a two-flop synchronizer precedes the
// stability counter; otherwise the wires are sampled directly.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bit0, bit1   : raw wires
//   w_f          : filtered (accepted) wire pair, registered
//   w_next       : current sample, valid as the new value when w_upd is high
//   w_upd        : w_f takes w_next on this edge
// -----------------------------------------------------------------------------
module dual_rail_filter
    import dual_rail_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   bit0,
    input  logic   bit1,
    output wpair_t w_f,
    output wpair_t w_next,
    output logic   w_upd
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

    wpair_t     samp_s;
    wpair_t     w_f_r;
    wpair_t     cand_r;
    wpair_t     cand_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       upd_s;

`ifdef DUAL_RAIL_SYNC_EN
    wpair_t sync1_r;
    wpair_t sync2_r;

    // Two-flop synchronizer for the asynchronous wire pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= W_00;
            sync2_r <= W_00;
        end else begin
            sync1_r <= {bit1, bit0};
            sync2_r <= sync1_r;
        end
    end

    assign samp_s = sync2_r;
`else
    assign samp_s = {bit1, bit0};
`endif

    // Count consecutive identical samples that differ from the accepted value;
    // a different sample restarts the count at one.
    always_comb begin
        cnt_nxt_s  = 4'd0;
        cand_nxt_s = samp_s;
        upd_s      = 1'b0;
        if (samp_s == w_f_r) begin
            cnt_nxt_s = 4'd0;
        end else begin
            if (samp_s == cand_r) begin
                cnt_nxt_s = cnt_r + 4'd1;
            end else begin
                cnt_nxt_s = 4'd1;
            end
            if (cnt_nxt_s >= STABLE_N) begin
                upd_s     = 1'b1;
                cnt_nxt_s = 4'd0;
            end else begin
                upd_s = 1'b0;
            end
        end
    end

    // Stability counter, candidate value and accepted wire pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 4'd0;
            cand_r <= W_00;
            w_f_r  <= W_00;
        end else begin
            cnt_r  <= cnt_nxt_s;
            cand_r <= cand_nxt_s;
            if (upd_s) begin
                w_f_r <= samp_s;
            end
        end
    end

    assign w_f    = w_f_r;
    assign w_next = samp_s;
    assign w_upd  = upd_s;

endmodule

// File: rtl/dual_rail_receiver.sv
// -----------------------------------------------------------------------------
// dual_rail_receiver
// Receiving end of the four-phase dual-rail link. Filtered wire transitions are
// decoded into one of six symbols (ZERO, ONE, X0, FE, FS, FD), each accepted
// non-final transition toggles ack, and the finished symbol is placed in a
// one-entry valid/ready slot. If the slot is busy at the final transition the
// receiver parks in HOLD with ack high, which stalls the sender.
// Macro DUAL_RAIL_SYNC_EN: adds a two-flop synchronizer in dual_rail_filter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   link       : dual_rail_receiver_if.slave (bit0/bit1/ack, sym/sym_valid/
//                sym_ready, err)
// Parameter STABLE_CYCLES (1..15): samples a new wire value must hold.
// -----------------------------------------------------------------------------
module dual_rail_receiver
    import dual_rail_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    dual_rail_receiver_if.slave  link
);

    localparam logic [3:0] ST_IDLE = S_IDLE;
    localparam logic [3:0] ST_A0   = S_A0;
    localparam logic [3:0] ST_A1   = S_A1;
    localparam logic [3:0] ST_B0   = S_B0;
    localparam logic [3:0] ST_B1   = S_B1;
    localparam logic [3:0] ST_C_X0 = S_C_X0;
    localparam logic [3:0] ST_C_FS = S_C_FS;
    localparam logic [3:0] ST_C_FE = S_C_FE;
    localparam logic [3:0] ST_C_FD = S_C_FD;
    localparam logic [3:0] ST_HOLD = S_HOLD;
    localparam logic [3:0] ST_ERR  = S_ERR;

    wpair_t     w_f_s;
    wpair_t     w_next_s;
    wpair_t     w_eff_s;
    logic       w_upd_s;

    logic [3:0] state_r, state_nxt_s, step_state_s;
    logic       ack_r, ack_nxt_s;
    logic [2:0] sym_r, sym_nxt_s;
    logic [2:0] hold_sym_r, hold_sym_nxt_s;
    logic       sym_valid_r, sym_valid_nxt_s;
    logic       err_r;

    logic       step_s, fin_s, viol_s, release_s, err_clear_s, load_s;
    logic [2:0] fin_code_s;
    logic       xfer_s, slot_free_s;

    dual_rail_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .bit0   (link.bit0),
        .bit1   (link.bit1),
        .w_f    (w_f_s),
        .w_next (w_next_s),
        .w_upd  (w_upd_s)
    );

    assign w_eff_s     = w_upd_s ? w_next_s : w_f_s;
    assign xfer_s      = sym_valid_r & link.sym_ready;
    assign slot_free_s = ~sym_valid_r | link.sym_ready;

    // Classify the current filtered event against the legal transition table.
    always_comb begin
        step_s       = 1'b0;
        step_state_s = state_r;
        fin_s        = 1'b0;
        fin_code_s   = SYM_ZERO;
        viol_s       = 1'b0;
        release_s    = 1'b0;
        err_clear_s  = 1'b0;
        if (state_r > ST_ERR) begin
            viol_s = 1'b1;
        end else if (state_r == ST_ERR) begin
            err_clear_s = (w_eff_s == W_00);
        end else if (state_r == ST_HOLD) begin
            // the sender must not move while ack is still high
            viol_s    = w_upd_s;
            release_s = ~w_upd_s & slot_free_s;
        end else if (w_upd_s) begin
            case ({state_r, w_next_s})
                {ST_IDLE, W_01}: begin step_s = 1'b1; step_state_s = ST_A0;   end
                {ST_IDLE, W_10}: begin step_s = 1'b1; step_state_s = ST_A1;   end
                {ST_A0,   W_11}: begin step_s = 1'b1; step_state_s = ST_B0;   end
                {ST_A1,   W_11}: begin step_s = 1'b1; step_state_s = ST_B1;   end
                {ST_B0,   W_01}: begin step_s = 1'b1; step_state_s = ST_C_X0; end
                {ST_B0,   W_10}: begin step_s = 1'b1; step_state_s = ST_C_FS; end
                {ST_B1,   W_10}: begin step_s = 1'b1; step_state_s = ST_C_FE; end
                {ST_B1,   W_01}: begin step_s = 1'b1; step_state_s = ST_C_FD; end
                {ST_A0,   W_00}: begin fin_s  = 1'b1; fin_code_s   = SYM_ZERO; end
                {ST_A1,   W_00}: begin fin_s  = 1'b1; fin_code_s   = SYM_ONE;  end
                {ST_C_X0, W_00}: begin fin_s  = 1'b1; fin_code_s   = SYM_X0;   end
                {ST_C_FS, W_00}: begin fin_s  = 1'b1; fin_code_s   = SYM_FS;   end
                {ST_C_FE, W_00}: begin fin_s  = 1'b1; fin_code_s   = SYM_FE;   end
                {ST_C_FD, W_00}: begin fin_s  = 1'b1; fin_code_s   = SYM_FD;   end
                default:         begin viol_s = 1'b1; end
            endcase
        end else begin
            step_s = 1'b0;
        end
    end

    // Resolve the classified event into next state, ack level and slot load.
    always_comb begin
        state_nxt_s    = state_r;
        ack_nxt_s      = ack_r;
        sym_nxt_s      = sym_r;
        hold_sym_nxt_s = hold_sym_r;
        load_s         = 1'b0;
        if (viol_s) begin
            state_nxt_s = ST_ERR;
            ack_nxt_s   = 1'b0;
        end else if (err_clear_s) begin
            state_nxt_s = ST_IDLE;
        end else if (release_s) begin
            load_s      = 1'b1;
            sym_nxt_s   = hold_sym_r;
            ack_nxt_s   = 1'b0;
            state_nxt_s = ST_IDLE;
        end else if (fin_s) begin
            if (slot_free_s) begin
                load_s      = 1'b1;
                sym_nxt_s   = fin_code_s;
                ack_nxt_s   = 1'b0;
                state_nxt_s = ST_IDLE;
            end else begin
                // ack stays high so the sender cannot start the next symbol
                hold_sym_nxt_s = fin_code_s;
                state_nxt_s    = ST_HOLD;
            end
        end else if (step_s) begin
            state_nxt_s = step_state_s;
            ack_nxt_s   = ~ack_r;
        end else begin
            state_nxt_s = state_r;
        end

        if (load_s) begin
            sym_valid_nxt_s = 1'b1;
        end else if (xfer_s) begin
            sym_valid_nxt_s = 1'b0;
        end else begin
            sym_valid_nxt_s = sym_valid_r;
        end
    end

    // FSM, ack, output slot and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ack_r       <= 1'b0;
            sym_r       <= SYM_ZERO;
            hold_sym_r  <= SYM_ZERO;
            sym_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ack_r       <= ack_nxt_s;
            sym_r       <= sym_nxt_s;
            hold_sym_r  <= hold_sym_nxt_s;
            sym_valid_r <= sym_valid_nxt_s;
            err_r       <= viol_s;
        end
    end

    assign link.ack       = ack_r;
    assign link.sym       = sym_r;
    assign link.sym_valid = sym_valid_r;
    assign link.err       = err_r;

endmodule

// File: tb/tb_dual_rail_receiver.sv
// -----------------------------------------------------------------------------
// tb_dual_rail_receiver
// Acts as four-phase dual-rail sender and as randomised consumer. Symbols are
// generated from the legal wire sequences; each completed symbol code is queued
// and a separate monitor pops and compares on every sym transfer. Err pulses
// are counted against the number of violations injected.
// -----------------------------------------------------------------------------
module tb_dual_rail_receiver;
    import dual_rail_pkg::*;

    localparam int SC = 2;
`ifdef DUAL_RAIL_SYNC_EN
    localparam int LAT = SC + 2;
`else
    localparam int LAT = SC;
`endif

    logic clk = 1'b0;
    logic rst_n;

    dual_rail_receiver_if lnk ();

    dual_rail_receiver #(.STABLE_CYCLES(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (lnk)
    );

    always #5 clk = ~clk;

    int         checks    = 0;
    int         failures  = 0;
    int         err_seen  = 0;
    int         err_exp   = 0;
    logic [2:0] exp_q[$];
    logic       ready_force = 1'b1;
    logic       ready_rand  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // wire sequence of each symbol code, first step in the top bits
    function automatic logic [1:0] seq_at(input int code, input int i);
        logic [7:0] s;
        case (code)
            0:       s = {2'b01, 2'b00, 2'b00, 2'b00};
            1:       s = {2'b10, 2'b00, 2'b00, 2'b00};
            2:       s = {2'b01, 2'b11, 2'b01, 2'b00};
            3:       s = {2'b10, 2'b11, 2'b10, 2'b00};
            4:       s = {2'b01, 2'b11, 2'b10, 2'b00};
            default: s = {2'b10, 2'b11, 2'b01, 2'b00};
        endcase
        return s[7 - 2*i -: 2];
    endfunction

    // consumer: ready changes just after the rising edge
    initial begin
        lnk.sym_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) lnk.sym_ready = 1'($urandom_range(0, 1));
            else            lnk.sym_ready = ready_force;
        end
    end

    // monitor: symbol scoreboard and err pulse counting
    initial begin
        logic err_prev;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (lnk.sym_valid && lnk.sym_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sym_unexpected: got %0d, expected no symbol", lnk.sym);
                    end else begin
                        check("sym_code", 32'(lnk.sym), 32'(exp_q.pop_front()));
                    end
                end
                if (lnk.err) begin
                    err_seen++;
                    if (err_prev) begin
                        checks++;
                        failures++;
                        $display("FAIL err_width: got err high for 2+ cycles, expected 1");
                    end
                end
                err_prev = lnk.err;
            end else begin
                err_prev = 1'b0;
            end
        end
    end

    task automatic wait_ack(input logic val, input string name);
        int n;
        n = 0;
        while (lnk.ack !== val && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(lnk.ack), 32'(val));
    endtask

    task automatic step(input logic [1:0] w, input logic exp_ack, input string name);
        @(negedge clk);
        {lnk.bit1, lnk.bit0} = w;
        repeat (LAT + 2) @(negedge clk);
        wait_ack(exp_ack, name);
    endtask

    // bad_idx < 0: legal symbol; otherwise flip both wires at that step
    task automatic send_symbol(input int code, input int bad_idx);
        int         len;
        int         e0;
        logic [1:0] cur;
        logic [1:0] w;
        len = (code < 2) ? 2 : 4;
        cur = 2'b00;
        for (int i = 0; i < len; i++) begin
            if (i == bad_idx) begin
                e0 = err_seen;
                err_exp++;
                step(cur ^ 2'b11, 1'b0, "ack_after_violation");
                check("err_pulse", 32'(err_seen - e0), 32'd1);
                step(2'b00, 1'b0, "ack_after_recovery");
                return;
            end
            w = seq_at(code, i);
            if (i == len - 1) begin
                exp_q.push_back(3'(code));
                step(w, 1'b0, "ack_final");
            end else begin
                step(w, (i % 2 == 0) ? 1'b1 : 1'b0, "ack_step");
            end
            cur = w;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int e0;
        int code;
        int bad;
        rst_n    = 1'b0;
        lnk.bit0 = 1'b0;
        lnk.bit1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack",       32'(lnk.ack),       32'd0);
        check("rst_sym",       32'(lnk.sym),       32'd0);
        check("rst_sym_valid", 32'(lnk.sym_valid), 32'd0);
        check("rst_err",       32'(lnk.err),       32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ZERO with latency measurement
        lnk.bit0 = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (lnk.ack !== 1'b1 && n < 20);
        check("ack_rise_latency", 32'(n), 32'(LAT));
        @(negedge clk);
        exp_q.push_back(SYM_ZERO);
        lnk.bit0 = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (lnk.ack !== 1'b0 && n < 20);
        check("ack_fall_latency", 32'(n), 32'(LAT));
        check("zero_sym_valid", 32'(lnk.sym_valid), 32'd1);
        check("zero_sym",       32'(lnk.sym),       32'(SYM_ZERO));
        @(posedge clk); #1;
        check("zero_valid_one_cycle", 32'(lnk.sym_valid), 32'd0);

        // FS: ack 1,0,1,0, no err
        send_symbol(4, -1);
        check("fs_no_err", 32'(err_seen), 32'd0);

        // back-pressure: ONE stays in slot, ZERO parks in HOLD
        ready_force = 1'b0;
        repeat (3) @(negedge clk);
        send_symbol(1, -1);
        step(2'b01, 1'b1, "bp_a0_ack");
        exp_q.push_back(SYM_ZERO);
        step(2'b00, 1'b1, "bp_hold_ack");
        check("bp_sym_one",   32'(lnk.sym),       32'(SYM_ONE));
        check("bp_valid_one", 32'(lnk.sym_valid), 32'd1);
        ready_force = 1'b1;
        wait_ack(1'b0, "bp_release_ack");
        check("bp_sym_zero",   32'(lnk.sym),       32'(SYM_ZERO));
        check("bp_valid_zero", 32'(lnk.sym_valid), 32'd1);

        // illegal 00->11 then FD
        repeat (3) @(negedge clk);
        send_symbol(5, 0);
        send_symbol(5, -1);

        // one-cycle glitch on bit1
        e0 = err_seen;
        @(negedge clk); lnk.bit1 = 1'b1;
        @(negedge clk); lnk.bit1 = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("glitch_ack", 32'(lnk.ack), 32'd0);
        check("glitch_err", 32'(err_seen), 32'(e0));
        send_symbol(0, -1);

        // reset inside B0 of X0; wires at 11 after release are illegal
        repeat (3) @(negedge clk);
        step(2'b01, 1'b1, "x0_a0_ack");
        step(2'b11, 1'b0, "x0_b0_ack");
        rst_n = 1'b0;
        #1;
        check("midrst_ack",   32'(lnk.ack),       32'd0);
        check("midrst_valid", 32'(lnk.sym_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e0 = err_seen;
        err_exp++;
        repeat (LAT + 3) @(negedge clk);
        check("midrst_err_pulse", 32'(err_seen - e0), 32'd1);
        step(2'b00, 1'b0, "midrst_recover_ack");

        // reset inside A0 while ack is high; 01 at release is a fresh first step
        step(2'b01, 1'b1, "a0rst_ack_before");
        rst_n = 1'b0;
        #1;
        check("a0rst_ack", 32'(lnk.ack), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        wait_ack(1'b1, "a0rst_fresh_ack");
        exp_q.push_back(SYM_ZERO);
        step(2'b00, 1'b0, "a0rst_final_ack");

        // randomized traffic with random back-pressure and injected violations
        ready_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            code = int'($urandom_range(0, 5));
            if ($urandom_range(0, 5) == 0) bad = int'($urandom_range(0, (code < 2) ? 1 : 3));
            else                           bad = -1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_symbol(code, bad);
        end

        ready_rand  = 1'b0;
        ready_force = 1'b1;
        repeat (10) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("err_total",     32'(err_seen),     32'(err_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
